lcd_hex_scanner: RTL and testbench
==================================

Name: lcd_hex_scanner

Overview:
- Parametrised successor of the fixed 4-digit LCD output path.
- Snapshots an N-digit value and converts each nibble to an LCD character code, MSD first.
- Writes the characters to consecutive DDRAM addresses through lcd_ctrl with a ready/enable handshake.
- Rewrites only on value change or periodic refresh; optional leading-zero blanking.

Parameters:
NUM_DIGITS, 4, hex digits displayed (1..16)
BASE_ADDR, 7'h00, DDRAM address of the most significant digit
REFRESH_CYC, 1000000, MCLK cycles between forced full rewrites (>=1)
SETUP_CYC, 2, cycles addr/data are held stable with oEn=0 before the strobe (>=1)
BLANK_LZ, 0, 1 = leading zeros shown as space (0x20); the least significant digit is never blanked

Ports:
MCLK  in  1  system clock
RESET  in  1  asynchronous active-low reset
iValue  in  4*NUM_DIGITS  value to display
iReady  in  1  lcd_ctrl can accept a write
oAddr  out  7  DDRAM address to lcd_ctrl
oData  out  8  character code to lcd_ctrl
oEn  out  1  write strobe to lcd_ctrl, one-cycle pulse
oBusy  out  1  high while a frame is in progress
oFrameDone  out  1  one-cycle pulse after the last digit's write is accepted

Behaviour:
- Reset (RESET=0, async): state IDLE; oAddr=0, oData=0x20, oEn=0, oBusy=0, oFrameDone=0; snapshot=0; refresh counter=0; force_pending=1, so the first frame starts immediately after reset release.
- Refresh counter: free-running 0..REFRESH_CYC-1. On wrap it sets force_pending. force_pending clears when a frame starts.
- FSM states: IDLE, LOAD, SETUP, STROBE, WAIT.
  - IDLE: if iValue != snapshot or force_pending, go to LOAD; otherwise stay. oBusy=0.
  - LOAD (1 cycle): snapshot<=iValue, digit index<=0, oBusy<=1. Go to SETUP.
  - SETUP: oAddr=BASE_ADDR+idx, oData=char(idx), oEn=0. Hold SETUP_CYC cycles, then go to STROBE once iReady=1. If iReady=0, stay with outputs held.
  - STROBE: oEn=1 for exactly one cycle; oAddr/oData unchanged. Go to WAIT.
  - WAIT: wait for iReady. If iReady is already 1 in the cycle after STROBE, treat it as accepted. Then:
    - idx < NUM_DIGITS-1: idx++, go to SETUP.
    - otherwise: pulse oFrameDone for 1 cycle, go to IDLE; oBusy drops in the same cycle.
- Digit order: idx 0 = iValue[4N-1:4N-4] (MSD) at BASE_ADDR; the last idx = nibble [3:0].
- Address arithmetic: 7-bit modulo-128 wrap (BASE_ADDR=7'h7E, N=4 writes 7E,7F,00,01).
- char mapping: 0-9 -> 0x30-0x39; A-F -> 0x41-0x46.
- Blanking (BLANK_LZ=1): digits before the first non-zero nibble become 0x20. The LSD is always shown, so value 0 displays "   0".
- iValue changes mid-frame: ignored. The frame completes from the snapshot. IDLE then sees the mismatch and starts a new frame next cycle.
- Refresh wrap mid-frame: force_pending is set and serviced after the current frame. Multiple wraps collapse into one pending.
- Simultaneous change and force in IDLE: one frame only; both are cleared.
- Reset mid-frame: abort immediately to the reset values. oEn drops asynchronously. A full frame follows release.
- Latency: iValue change in IDLE -> first oEn after 1 (LOAD) + SETUP_CYC cycles, with iReady=1.

Decomposition:
- Shared package lcd_pkg:
  - state enum
  - LCD_SPACE=8'h20
  - ASCII_ZERO=8'h30
  - ASCII_A=8'h41
  - LCD_ADDR_W=7
- Sub-module hex_to_ascii: combinational nibble -> 8-bit char. Instantiated once on the nibble selected by idx; blanking is applied in the parent.

Test Plan:
- Reset release, iValue=16'h1A2F, iReady=1 -> writes (00,'1'=0x31),(01,'A'=0x41),(02,'2'=0x32),(03,'F'=0x46). Each oEn is a 1-cycle pulse; oFrameDone follows the 4th write.
- iValue held constant, REFRESH_CYC=50 -> identical 4-write frame repeats every 50 cycles; no writes in between.
- iReady held 0 for 10 cycles during SETUP of digit 2 -> oAddr=02 and oData stable, no oEn until iReady=1; strobe then issues.
- iValue 16'h1234 -> 16'hBEEF changed at cycle 3 of a frame -> frame finishes 31,32,33,34, then an immediate frame writes 42,45,45,46.
- BLANK_LZ=1, iValue=16'h0050 -> data 20,20,35,30; iValue=0 -> 20,20,20,30.
- RESET asserted while oEn=1, BASE_ADDR=7'h7E -> oEn=0 the same cycle. After release, addresses 7E,7F,00,01 are written.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD hex scanner: FSM state encoding
// and the character codes written into the LCD's DDRAM.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SETUP  = 3'd2,
      ST_STROBE = 3'd3,
      ST_WAIT   = 3'd4
   } state_e;

   localparam int         LCD_ADDR_W = 7;
   localparam logic [7:0] LCD_SPACE  = 8'h20;
   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_A    = 8'h41;

endpackage

// File: rtl/hex_to_ascii.sv
// Combinational nibble to LCD character code: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
module hex_to_ascii
   import lcd_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [7:0] char_o
);

   // Map one hex nibble onto its character code
   always_comb begin
      char_o = ASCII_ZERO;
      if (nibble_i < 4'd10) begin
         char_o = ASCII_ZERO + {4'h0, nibble_i};
      end else begin
         char_o = ASCII_A + {4'h0, nibble_i} - 8'd10;
      end
   end

endmodule

// File: rtl/lcd_hex_scanner.sv
// Snapshots an N-digit hex value and writes it MSD-first to consecutive LCD
// DDRAM addresses, rewriting on value change or on a periodic refresh.
module lcd_hex_scanner
   import lcd_pkg::*;
#(
   parameter int                    NUM_DIGITS  = 4,
   parameter logic [LCD_ADDR_W-1:0] BASE_ADDR   = 7'h00,
   parameter int                    REFRESH_CYC = 1000000,
   parameter int                    SETUP_CYC   = 2,
   parameter bit                    BLANK_LZ    = 1'b0
) (
   input  logic                    MCLK,
   input  logic                    RESET,
   input  logic [4*NUM_DIGITS-1:0] iValue,
   input  logic                    iReady,
   output logic [LCD_ADDR_W-1:0]   oAddr,
   output logic [7:0]              oData,
   output logic                    oEn,
   output logic                    oBusy,
   output logic                    oFrameDone
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int REF_W = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
   localparam int SET_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYC - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETUP_CYC - 1);

   state_e                  state_q;
   logic [4*NUM_DIGITS-1:0] snap_q;
   logic [IDX_W-1:0]        idx_q;
   logic [SET_W-1:0]        set_cnt_q;
   logic [REF_W-1:0]        ref_cnt_q;
   logic                    force_q;

   logic                    start_s;
   logic                    wrap_s;
   logic [4*NUM_DIGITS-1:0] sel_val_s;
   logic [IDX_W-1:0]        sel_idx_s;
   logic [3:0]              nib_s;
   logic                    lead_zero_s;
   logic [7:0]              hex_char_s;
   logic [7:0]              next_char_s;
   logic [LCD_ADDR_W-1:0]   next_addr_s;

   assign start_s = (state_q == ST_IDLE) && ((iValue != snap_q) || force_q);
   assign wrap_s  = (ref_cnt_q == REF_LAST);

   // Digit about to be presented: digit 0 of the live value while loading,
   // otherwise the next digit of the snapshot.
   always_comb begin
      sel_val_s   = snap_q;
      sel_idx_s   = idx_q + IDX_W'(1);
      nib_s       = 4'h0;
      lead_zero_s = 1'b1;
      if (state_q == ST_LOAD) begin
         sel_val_s = iValue;
         sel_idx_s = '0;
      end else begin
         sel_val_s = snap_q;
         sel_idx_s = idx_q + IDX_W'(1);
      end
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (k == int'(sel_idx_s)) begin
            nib_s = sel_val_s[4*(NUM_DIGITS-1-k) +: 4];
         end else begin
            nib_s = nib_s;
         end
         if ((k <= int'(sel_idx_s)) && (sel_val_s[4*(NUM_DIGITS-1-k) +: 4] != 4'h0)) begin
            lead_zero_s = 1'b0;
         end else begin
            lead_zero_s = lead_zero_s;
         end
      end
   end

   hex_to_ascii u_hex (
      .nibble_i (nib_s),
      .char_o   (hex_char_s)
   );

   // Blanking and address for the digit about to be presented
   always_comb begin
      next_addr_s = BASE_ADDR + LCD_ADDR_W'(sel_idx_s);
      next_char_s = hex_char_s;
      if (BLANK_LZ && lead_zero_s && (sel_idx_s != LAST_IDX)) begin
         next_char_s = LCD_SPACE;
      end else begin
         next_char_s = hex_char_s;
      end
   end

   // Free-running refresh timer; a wrap that lands on a frame start still wins
   always_ff @(posedge MCLK or negedge RESET) begin
      if (!RESET) begin
         ref_cnt_q <= '0;
         force_q   <= 1'b1;
      end else begin
         if (wrap_s) begin
            ref_cnt_q <= '0;
         end else begin
            ref_cnt_q <= ref_cnt_q + REF_W'(1);
         end
         if (wrap_s) begin
            force_q <= 1'b1;
         end else if (start_s) begin
            force_q <= 1'b0;
         end else begin
            force_q <= force_q;
         end
      end
   end

   // Frame sequencer with registered handshake outputs
   always_ff @(posedge MCLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= ST_IDLE;
         snap_q     <= '0;
         idx_q      <= '0;
         set_cnt_q  <= '0;
         oAddr      <= '0;
         oData      <= LCD_SPACE;
         oEn        <= 1'b0;
         oBusy      <= 1'b0;
         oFrameDone <= 1'b0;
      end else begin
         oEn        <= 1'b0;
         oFrameDone <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               oBusy <= 1'b0;
               if (start_s) begin
                  state_q <= ST_LOAD;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               snap_q    <= iValue;
               idx_q     <= '0;
               set_cnt_q <= '0;
               oBusy     <= 1'b1;
               oAddr     <= next_addr_s;
               oData     <= next_char_s;
               state_q   <= ST_SETUP;
            end
            ST_SETUP: begin
               if (set_cnt_q != SET_LAST) begin
                  set_cnt_q <= set_cnt_q + SET_W'(1);
               end else if (iReady) begin
                  oEn     <= 1'b1;
                  state_q <= ST_STROBE;
               end else begin
                  state_q <= ST_SETUP;
               end
            end
            ST_STROBE: begin
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (!iReady) begin
                  state_q <= ST_WAIT;
               end else if (idx_q != LAST_IDX) begin
                  idx_q     <= idx_q + IDX_W'(1);
                  set_cnt_q <= '0;
                  oAddr     <= next_addr_s;
                  oData     <= next_char_s;
                  state_q   <= ST_SETUP;
               end else begin
                  oFrameDone <= 1'b1;
                  oBusy      <= 1'b0;
                  state_q    <= ST_IDLE;
               end
            end
            default: begin
               oBusy   <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_hex_scanner.sv
// Self-checking bench for lcd_hex_scanner: three configurations, writes logged
// by a monitor and compared against frames computed from the displayed value.
module tb_lcd_hex_scanner;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
   logic [15:0] val_a = 16'h0, val_b = 16'h0, val_c = 16'h0;
   logic        rdy_a = 1'b1, rdy_b = 1'b1, rdy_c = 1'b1;
   logic [6:0]  addr_a, addr_b, addr_c;
   logic [7:0]  data_a, data_b, data_c;
   logic        en_a, en_b, en_c, busy_a, busy_b, busy_c, fd_a, fd_b, fd_c;

   lcd_hex_scanner #(.NUM_DIGITS(4), .BASE_ADDR(7'h00), .REFRESH_CYC(50),
                     .SETUP_CYC(2), .BLANK_LZ(1'b0)) u_a (
      .MCLK(clk), .RESET(rst_a), .iValue(val_a), .iReady(rdy_a), .oAddr(addr_a),
      .oData(data_a), .oEn(en_a), .oBusy(busy_a), .oFrameDone(fd_a));

   lcd_hex_scanner #(.NUM_DIGITS(4), .BASE_ADDR(7'h00), .REFRESH_CYC(100000),
                     .SETUP_CYC(2), .BLANK_LZ(1'b0)) u_b (
      .MCLK(clk), .RESET(rst_b), .iValue(val_b), .iReady(rdy_b), .oAddr(addr_b),
      .oData(data_b), .oEn(en_b), .oBusy(busy_b), .oFrameDone(fd_b));

   lcd_hex_scanner #(.NUM_DIGITS(4), .BASE_ADDR(7'h7E), .REFRESH_CYC(100000),
                     .SETUP_CYC(3), .BLANK_LZ(1'b1)) u_c (
      .MCLK(clk), .RESET(rst_c), .iValue(val_c), .iReady(rdy_c), .oAddr(addr_c),
      .oData(data_c), .oEn(en_c), .oBusy(busy_c), .oFrameDone(fd_c));

   typedef struct {
      int         inst;
      int         cyc;
      logic [6:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t  wq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   fd_cnt[3];
   int   fd_cyc[3];
   int   pulse_err[3];
   int   last_addr[3];
   int   last_cyc[3];
   logic prev_en[3];
   int   a_first;

   task automatic log_inst(input int w, input logic en, input logic [6:0] a,
                           input logic [7:0] d, input logic fd);
      wr_t r;
      if (en === 1'b1) begin
         r.inst = w; r.cyc = cyc; r.addr = a; r.data = d;
         wq.push_back(r);
         last_addr[w] = int'(a);
         last_cyc[w] = cyc;
         if (prev_en[w] === 1'b1) pulse_err[w]++;
      end
      if (fd === 1'b1) begin
         fd_cnt[w]++;
         fd_cyc[w] = cyc;
      end
      prev_en[w] = en;
   endtask

   always @(negedge clk) begin
      cyc = cyc + 1;
      log_inst(0, en_a, addr_a, data_a, fd_a);
      log_inst(1, en_b, addr_b, data_b, fd_b);
      log_inst(2, en_c, addr_c, data_c, fd_c);
   end

   // Character the display must show for digit k (0 = most significant)
   function automatic logic [7:0] exp_char(input logic [15:0] v, input int k, input bit blank);
      int pos;
      int nib;
      pos = 4 * (3 - k);
      nib = int'((v >> pos) & 16'h000F);
      if (blank && k < 3 && (v >> pos) == 16'h0000) return 8'h20;
      if (nib < 10) return 8'(48 + nib);
      return 8'(65 + nib - 10);
   endfunction

   function automatic int pending(input int w);
      int n;
      n = 0;
      foreach (wq[i]) if (wq[i].inst == w) n++;
      return n;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_fd(input int w, input int target, input int budget, input string tag);
      int n;
      n = 0;
      while (fd_cnt[w] < target && n < budget) begin
         tick(1);
         n++;
      end
      checks++;
      if (fd_cnt[w] < target) begin
         errors++;
         $display("FAIL %s timeout: frames done %0d, required %0d", tag, fd_cnt[w], target);
      end
   endtask

   // Pops the next four writes of instance w and compares them with the frame of v
   task automatic check_frame(input int w, input logic [15:0] v, input logic [6:0] base,
                              input bit blank, input int spacing, input string tag,
                              output int first_cyc);
      int pos;
      int prev;
      logic [6:0] ea;
      logic [7:0] ed;
      first_cyc = -1;
      prev = -1;
      for (int k = 0; k < 4; k++) begin
         pos = -1;
         for (int i = 0; i < wq.size(); i++) begin
            if (wq[i].inst == w) begin
               pos = i;
               break;
            end
         end
         ea = 7'((int'(base) + k) % 128);
         ed = exp_char(v, k, blank);
         checks++;
         if (pos < 0) begin
            errors++;
            $display("FAIL %s digit %0d: no write seen, required addr %h data %h", tag, k, ea, ed);
         end else begin
            if (wq[pos].addr !== ea || wq[pos].data !== ed) begin
               errors++;
               $display("FAIL %s digit %0d: got addr %h data %h, required addr %h data %h",
                        tag, k, wq[pos].addr, wq[pos].data, ea, ed);
            end
            if (k == 0) begin
               first_cyc = wq[pos].cyc;
            end else if (spacing > 0) begin
               checks++;
               if (wq[pos].cyc - prev != spacing) begin
                  errors++;
                  $display("FAIL %s digit %0d spacing: got %0d cycles, required %0d",
                           tag, k, wq[pos].cyc - prev, spacing);
               end
            end
            prev = wq[pos].cyc;
            wq.delete(pos);
         end
      end
   endtask

   task automatic test_reset;
      int c0;
      tick(3);
      checks += 5;
      if (addr_a !== 7'h00) begin errors++; $display("FAIL reset_addr: got %h, required 00", addr_a); end
      if (data_a !== 8'h20) begin errors++; $display("FAIL reset_data: got %h, required 20", data_a); end
      if (en_a !== 1'b0) begin errors++; $display("FAIL reset_en: got %b, required 0", en_a); end
      if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy_a); end
      if (fd_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", fd_a); end
      val_a = 16'h1A2F;
      rdy_a = 1'b1;
      c0 = cyc;
      rst_a = 1'b1;
      wait_fd(0, 1, 100, "first_frame");
      checks += 2;
      if (fd_a !== 1'b1 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL frame_end: got done %b busy %b, required 1 0", fd_a, busy_a);
      end
      check_frame(0, 16'h1A2F, 7'h00, 1'b0, 4, "first_frame", a_first);
      if (a_first - c0 != 4) begin
         errors++;
         $display("FAIL first_latency: got %0d cycles, required 4", a_first - c0);
      end
      checks++;
      if (fd_cyc[0] != a_first + 14) begin
         errors++;
         $display("FAIL done_timing: got cycle %0d, required %0d", fd_cyc[0], a_first + 14);
      end
      tick(1);
      checks++;
      if (fd_a !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b, required 0", fd_a); end
   endtask

   task automatic test_refresh;
      int f1;
      int f2;
      wait_fd(0, 3, 160, "refresh");
      check_frame(0, 16'h1A2F, 7'h00, 1'b0, 4, "refresh1", f1);
      check_frame(0, 16'h1A2F, 7'h00, 1'b0, 4, "refresh2", f2);
      checks += 3;
      if (f1 - a_first != 50) begin errors++; $display("FAIL refresh_period1: got %0d, required 50", f1 - a_first); end
      if (f2 - f1 != 50) begin errors++; $display("FAIL refresh_period2: got %0d, required 50", f2 - f1); end
      if (pending(0) != 0) begin errors++; $display("FAIL refresh_extra: got %0d extra writes, required 0", pending(0)); end
      rst_a = 1'b0;
   endtask

   task automatic test_ready_stall;
      int f;
      int n;
      rdy_b = 1'b1;
      rst_b = 1'b1;
      wait_fd(1, 1, 100, "zero_frame");
      check_frame(1, 16'h0000, 7'h00, 1'b0, 4, "zero_frame", f);
      val_b = 16'h5C7D;
      n = 0;
      while (!(last_addr[1] == 1 && last_cyc[1] == cyc) && n < 100) begin
         tick(1);
         n++;
      end
      checks++;
      if (n >= 100) begin errors++; $display("FAIL stall_setup: digit 1 write not seen, required within 100 cycles"); end
      tick(2);
      rdy_b = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         checks++;
         if (addr_b !== 7'h02 || data_b !== 8'h37 || en_b !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold %0d: got addr %h data %h en %b, required 02 37 0", i, addr_b, data_b, en_b);
         end
      end
      rdy_b = 1'b1;
      tick(1);
      checks++;
      if (!(last_addr[1] == 2 && last_cyc[1] == cyc)) begin
         errors++;
         $display("FAIL stall_release: got last write addr %0d at %0d, required 2 at %0d", last_addr[1], last_cyc[1], cyc);
      end
      wait_fd(1, 2, 100, "stall_frame");
      check_frame(1, 16'h5C7D, 7'h00, 1'b0, 0, "stall_frame", f);
   endtask

   task automatic test_midframe_change;
      int c0;
      int base;
      int fd1;
      int f1;
      int f2;
      base = fd_cnt[1];
      c0 = cyc;
      val_b = 16'h1234;
      tick(3);
      val_b = 16'hBEEF;
      wait_fd(1, base + 1, 100, "change_frame1");
      fd1 = fd_cyc[1];
      wait_fd(1, base + 2, 100, "change_frame2");
      check_frame(1, 16'h1234, 7'h00, 1'b0, 4, "change_old", f1);
      check_frame(1, 16'hBEEF, 7'h00, 1'b0, 4, "change_new", f2);
      checks += 3;
      if (f1 - c0 != 4) begin errors++; $display("FAIL change_latency: got %0d, required 4", f1 - c0); end
      if (f2 - fd1 != 4) begin errors++; $display("FAIL change_restart: got %0d, required 4", f2 - fd1); end
      if (pending(1) != 0) begin errors++; $display("FAIL change_extra: got %0d extra writes, required 0", pending(1)); end
   endtask

   task automatic test_random;
      logic [15:0] cur;
      logic [15:0] v;
      int base;
      int n;
      int f;
      cur = 16'hBEEF;
      for (int it = 0; it < 8; it++) begin
         v = 16'($urandom);
         if (v == cur) v = v ^ 16'h0001;
         val_b = v;
         base = fd_cnt[1];
         n = 0;
         while (fd_cnt[1] < base + 1 && n < 600) begin
            rdy_b = ($urandom_range(0, 3) != 0);
            tick(1);
            n++;
         end
         rdy_b = 1'b1;
         checks++;
         if (fd_cnt[1] < base + 1) begin errors++; $display("FAIL random %0d timeout: value %h", it, v); end
         check_frame(1, v, 7'h00, 1'b0, 0, "random", f);
         cur = v;
      end
   endtask

   task automatic test_blank;
      logic [15:0] vals[5];
      int f;
      vals = '{16'h0050, 16'h0000, 16'h0F00, 16'h8000, 16'h0007};
      rdy_c = 1'b1;
      for (int i = 0; i < 5; i++) begin
         val_c = vals[i];
         if (i == 0) rst_c = 1'b1;
         wait_fd(2, i + 1, 150, "blank");
         check_frame(2, vals[i], 7'h7E, 1'b1, 5, "blank", f);
      end
   endtask

   task automatic test_reset_midframe;
      int n;
      int base;
      int f;
      val_c = 16'hA5C3;
      n = 0;
      while (en_c !== 1'b1 && n < 100) begin
         tick(1);
         n++;
      end
      base = fd_cnt[2];
      rst_c = 1'b0;
      #1;
      checks += 2;
      if (en_c !== 1'b0 || busy_c !== 1'b0) begin
         errors++;
         $display("FAIL abort_strobe: got en %b busy %b, required 0 0", en_c, busy_c);
      end
      if (addr_c !== 7'h00 || data_c !== 8'h20) begin
         errors++;
         $display("FAIL abort_outputs: got addr %h data %h, required 00 20", addr_c, data_c);
      end
      for (int i = wq.size() - 1; i >= 0; i--) if (wq[i].inst == 2) wq.delete(i);
      tick(2);
      rst_c = 1'b1;
      wait_fd(2, base + 1, 150, "after_abort");
      check_frame(2, 16'hA5C3, 7'h7E, 1'b1, 5, "after_abort", f);
   endtask

   initial begin
      test_reset();
      test_refresh();
      test_ready_stall();
      test_midframe_change();
      test_random();
      test_blank();
      test_reset_midframe();
      tick(5);
      for (int w = 0; w < 3; w++) begin
         checks++;
         if (pulse_err[w] != 0) begin
            errors++;
            $display("FAIL strobe_width inst %0d: got %0d multi-cycle strobes, required 0", w, pulse_err[w]);
         end
      end
      checks++;
      if (wq.size() != 0) begin
         errors++;
         $display("FAIL stray_writes: got %0d, required 0", wq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
